// File: rtl/video_timing.sv
// Raster timing generator: free-running pixel/line counters decoded into
// registered active-area coordinates, data enable, syncs and start pulses.
module video_timing #(
    parameter int unsigned HOR_ACTIVE_PIXELS = 1280,
    parameter int unsigned HOR_FRONT_PORCH   = 110,
    parameter int unsigned HOR_SYNC          = 40,
    parameter int unsigned HOR_BACK_PORCH    = 220,
    parameter int unsigned VER_ACTIVE_PIXELS = 720,
    parameter int unsigned VER_FRONT_PORCH   = 5,
    parameter int unsigned VER_SYNC          = 5,
    parameter int unsigned VER_BACK_PORCH    = 20,
    parameter int unsigned SYNC_ACTIVE_HIGH  = 1,
    localparam int unsigned H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH,
    localparam int unsigned V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH,
    localparam int unsigned X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
    localparam int unsigned Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    // Decode bounds are one bit wider than the counters so an end bound equal
    // to the total (zero back porch) still fits without wrapping.
    localparam logic [HW:0] H_ACT_END   = (HW+1)'(HOR_ACTIVE_PIXELS);
    localparam logic [HW:0] H_SYNC_BEG  = (HW+1)'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
    localparam logic [HW:0] H_SYNC_END  = (HW+1)'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC);
    localparam logic [VW:0] V_ACT_END   = (VW+1)'(VER_ACTIVE_PIXELS);
    localparam logic [VW:0] V_SYNC_BEG  = (VW+1)'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
    localparam logic [VW:0] V_SYNC_END  = (VW+1)'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic          SYNC_ON   = 1'(SYNC_ACTIVE_HIGH != 0);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [HW:0]   h_ext;
    logic [VW:0]   v_ext;
    logic          de_c;
    logic          hs_c;
    logic          vs_c;
    logic          h_last_c;

    // Combinational decode of the current counter position
    always_comb begin
        h_ext    = {1'b0, h_cnt};
        v_ext    = {1'b0, v_cnt};
        de_c     = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        hs_c     = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
        vs_c     = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
        h_last_c = (h_cnt == H_LAST);
    end

    // Pixel and line counters; line counter advances on pixel wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (h_last_c) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    // Registered outputs, one cycle behind the counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x           <= de_c ? X_WIDTH'(h_cnt) : '0;
            y           <= de_c ? Y_WIDTH'(v_cnt) : '0;
            de          <= de_c;
            hsync       <= hs_c ? SYNC_ON : ~SYNC_ON;
            vsync       <= vs_c ? SYNC_ON : ~SYNC_ON;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: small-raster instances checked every cycle against
// an arithmetic raster model, plus literal pins on small and default rasters.
module tb_video_timing;

    localparam int HA = 16, HF = 4, HS = 3, HB = 5;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 28
    localparam int VT = VA + VF + VS + VB;   // 15
    localparam int FT = HT * VT;             // 420

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [3:0]  a_x, b_x;
    logic [2:0]  a_y, b_y;
    logic        a_de, a_hs, a_vs, a_ls, a_fs;
    logic        b_de, b_hs, b_vs, b_ls, b_fs;
    logic [10:0] c_x;
    logic [9:0]  c_y;
    logic        c_de, c_hs, c_vs, c_ls, c_fs;

    int checks = 0;
    int passed = 0;
    int edges;
    bit first_run = 1'b1;
    int de_cnt = 0, vs_cnt = 0, hs_cnt = 0, ls_cnt = 0, fs_cnt = 0;

    video_timing #(
        .HOR_ACTIVE_PIXELS(HA), .HOR_FRONT_PORCH(HF), .HOR_SYNC(HS), .HOR_BACK_PORCH(HB),
        .VER_ACTIVE_PIXELS(VA), .VER_FRONT_PORCH(VF), .VER_SYNC(VS), .VER_BACK_PORCH(VB),
        .SYNC_ACTIVE_HIGH(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .x(a_x), .y(a_y), .de(a_de), .hsync(a_hs),
        .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs)
    );

    video_timing #(
        .HOR_ACTIVE_PIXELS(HA), .HOR_FRONT_PORCH(HF), .HOR_SYNC(HS), .HOR_BACK_PORCH(HB),
        .VER_ACTIVE_PIXELS(VA), .VER_FRONT_PORCH(VF), .VER_SYNC(VS), .VER_BACK_PORCH(VB),
        .SYNC_ACTIVE_HIGH(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .x(b_x), .y(b_y), .de(b_de), .hsync(b_hs),
        .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs)
    );

    video_timing dut_c (
        .clk(clk), .rst_n(rst_n), .x(c_x), .y(c_y), .de(c_de), .hsync(c_hs),
        .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs)
    );

    always #5 clk = ~clk;

    // Rising edges seen since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edges);
    endtask

    // Raster model: position p (pixels since release) -> expected outputs
    function automatic void model(input int p, output int ex, output int ey, output int ede,
                                  output int ehs, output int evs, output int els, output int efs);
        int h, v;
        h   = p % HT;
        v   = (p / HT) % VT;
        ede = (h < HA && v < VA) ? 1 : 0;
        ex  = ede ? h : 0;
        ey  = ede ? v : 0;
        ehs = (h >= HA + HF && h < HA + HF + HS) ? 1 : 0;
        evs = (v >= VA + VF && v < VA + VF + VS) ? 1 : 0;
        els = (h == 0) ? 1 : 0;
        efs = (h == 0 && v == 0) ? 1 : 0;
    endfunction

    // Every-cycle comparison of both small instances against the model
    always @(negedge clk) begin
        int ex, ey, ede, ehs, evs, els, efs;
        if (!rst_n || edges == 0) begin
            ex = 0; ey = 0; ede = 0; ehs = 0; evs = 0; els = 0; efs = 0;
        end else begin
            model(edges - 1, ex, ey, ede, ehs, evs, els, efs);
        end
        chk("a_x", int'(a_x), ex);   chk("a_y", int'(a_y), ey);
        chk("a_de", int'(a_de), ede); chk("a_hsync", int'(a_hs), ehs);
        chk("a_vsync", int'(a_vs), evs); chk("a_line_start", int'(a_ls), els);
        chk("a_frame_start", int'(a_fs), efs);
        chk("b_x", int'(b_x), ex);   chk("b_y", int'(b_y), ey);
        chk("b_de", int'(b_de), ede); chk("b_hsync", int'(b_hs), 1 - ehs);
        chk("b_vsync", int'(b_vs), 1 - evs); chk("b_line_start", int'(b_ls), els);
        chk("b_frame_start", int'(b_fs), efs);
        if (first_run && rst_n && edges >= 1 && edges <= FT) begin
            de_cnt += int'(a_de);
            vs_cnt += int'(a_vs);
            hs_cnt += int'(a_hs);
            ls_cnt += int'(a_ls);
            fs_cnt += int'(a_fs);
        end
    end

    task automatic wait_edge(input int n);
        for (int i = 0; i < 5000 && edges < n; i++) @(negedge clk);
        if (edges != n) chk("wait_edge_timeout", edges, n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_c_hsync", int'(c_hs), 0);
        chk("rst_b_hsync", int'(b_hs), 1);
        chk("rst_c_fs", int'(c_fs), 0);
        rst_n = 1'b1;

        wait_edge(1);
        chk("c1_fs", int'(c_fs), 1); chk("c1_de", int'(c_de), 1);
        chk("c1_x", int'(c_x), 0);   chk("c1_y", int'(c_y), 0);
        chk("c1_ls", int'(c_ls), 1);
        chk("a1_fs", int'(a_fs), 1); chk("a1_de", int'(a_de), 1);
        wait_edge(2);
        chk("c2_x", int'(c_x), 1);   chk("c2_fs", int'(c_fs), 0);
        chk("a2_x", int'(a_x), 1);
        wait_edge(16);
        chk("a_lastpix_x", int'(a_x), 15); chk("a_lastpix_de", int'(a_de), 1);
        wait_edge(17);
        chk("a_blank_de", int'(a_de), 0); chk("a_blank_x", int'(a_x), 0);
        wait_edge(20);
        chk("a_pre_hsync", int'(a_hs), 0);
        wait_edge(21);
        chk("a_hsync_beg", int'(a_hs), 1); chk("b_hsync_beg", int'(b_hs), 0);
        wait_edge(212);
        chk("a_last_x", int'(a_x), 15); chk("a_last_y", int'(a_y), 7);
        chk("a_last_de", int'(a_de), 1);
        wait_edge(213);
        chk("a_after_de", int'(a_de), 0); chk("a_after_x", int'(a_x), 0);
        chk("a_after_y", int'(a_y), 0);
        wait_edge(421);
        chk("a_frame2_fs", int'(a_fs), 1);
        chk("frame_de_cycles", de_cnt, 128);
        chk("frame_vsync_cycles", vs_cnt, 56);
        chk("frame_hsync_cycles", hs_cnt, 45);
        chk("frame_line_starts", ls_cnt, 15);
        chk("frame_frame_starts", fs_cnt, 1);

        // Mid-hsync reset on line 5, column 21 of the second frame
        wait_edge(FT + 162);
        chk("a_mid_hsync", int'(a_hs), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        first_run = 1'b0;
        #1;
        chk("async_a_hsync", int'(a_hs), 0); chk("async_b_hsync", int'(b_hs), 1);
        chk("async_a_de", int'(a_de), 0);    chk("async_a_ls", int'(a_ls), 0);
        chk("async_c_hsync", int'(c_hs), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_edge(1);
        chk("r1_fs", int'(a_fs), 1); chk("r1_de", int'(a_de), 1);
        chk("r1_x", int'(a_x), 0);   chk("r1_y", int'(a_y), 0);
        chk("r1_c_fs", int'(c_fs), 1);
        wait_edge(2);
        chk("r2_x", int'(a_x), 1);   chk("r2_fs", int'(a_fs), 0);
        chk("r2_c_x", int'(c_x), 1);

        // Default raster hsync window (columns 1390..1429)
        wait_edge(1390);
        chk("c_hsync_pre", int'(c_hs), 0);
        wait_edge(1391);
        chk("c_hsync_first", int'(c_hs), 1);
        wait_edge(1430);
        chk("c_hsync_last", int'(c_hs), 1);
        wait_edge(1431);
        chk("c_hsync_post", int'(c_hs), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
